// File: rtl/uart_pkg.sv
// Shared UART constants: mode encodings, SCON bit positions, SFR addresses
// and the mode-0 shift period. Used by the SCON control and receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } uart_mode_e;

    localparam logic [2:0] SCON_RI_BIT  = 3'd0;
    localparam logic [2:0] SCON_TI_BIT  = 3'd1;
    localparam logic [2:0] SCON_RB8_BIT = 3'd2;
    localparam logic [2:0] SCON_TB8_BIT = 3'd3;
    localparam logic [2:0] SCON_REN_BIT = 3'd4;
    localparam logic [2:0] SCON_SM2_BIT = 3'd5;

    localparam logic [7:0] SFR_SCON = 8'h98;
    localparam logic [7:0] SFR_SBUF = 8'h99;
    localparam logic [7:0] SFR_BRL  = 8'h9A;
    localparam logic [7:0] SFR_PCON = 8'h87;

    localparam logic [3:0] T7_PERIOD = 4'd12;
    localparam logic [3:0] T7_LAST   = T7_PERIOD - 4'd1;

    // Modes 01/11 take their rate from the BRL reload divider.
    function automatic logic uses_brl(input uart_mode_e mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: BRL divider / fixed /2 base, /2 stage (bypassed by smod)
// and the 12-clock mode-0 shift counter, all restarted on a mode change.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  uart_mode_e mode,
    input  logic       restart,
    input  logic [7:0] brl,
    input  logic       smod,
    output logic       tc,
    output logic       t7
);

    logic [7:0] div_r;
    logic       half_r;
    logic       stage_r;
    logic [3:0] t7_cnt_r;
    logic       tc_r;
    logic       t7_r;
    logic       base_tick_s;

    // Select the base tick source for the current mode.
    always_comb begin
        base_tick_s = 1'b0;
        case (mode)
            MODE0:        base_tick_s = 1'b0;
            MODE2:        base_tick_s = half_r;
            MODE1, MODE3: base_tick_s = (div_r == 8'd0);
            default:      base_tick_s = 1'b0;
        endcase
    end

    // Counters and registered ticks; a restart reloads and silences this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= 8'd0;
            half_r   <= 1'b0;
            stage_r  <= 1'b0;
            t7_cnt_r <= 4'd0;
            tc_r     <= 1'b0;
            t7_r     <= 1'b0;
        end else if (restart) begin
            div_r    <= brl;
            half_r   <= 1'b0;
            stage_r  <= 1'b0;
            t7_cnt_r <= 4'd0;
            tc_r     <= 1'b0;
            t7_r     <= 1'b0;
        end else begin
            tc_r <= base_tick_s & (stage_r | smod);
            t7_r <= (mode == MODE0) && (t7_cnt_r == T7_LAST);
            if (base_tick_s) begin
                stage_r <= ~stage_r;
            end
            if (mode == MODE2) begin
                half_r <= ~half_r;
            end
            if (uses_brl(mode)) begin
                div_r <= (div_r == 8'd0) ? brl : (div_r - 8'd1);
            end
            if (mode == MODE0) begin
                t7_cnt_r <= (t7_cnt_r == T7_LAST) ? 4'd0 : (t7_cnt_r + 4'd1);
            end
        end
    end

    assign tc = tc_r;
    assign t7 = t7_r;

endmodule

// File: rtl/uart_scon_ctrl.sv
// 8051 UART serial control: SCON/BRL registers, SFR read mux, interrupt and
// baud ticks. Define UART_SMOD_EN to add the PCON.SMOD baud doubler.
module uart_scon_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] ADDR_SCON = SFR_SCON,
    parameter logic [7:0] ADDR_BRL  = SFR_BRL,
    parameter logic [7:0] ADDR_PCON = SFR_PCON,
    parameter logic [7:0] BRL_RESET = 8'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] AB,
    input  logic [7:0] din,
    input  logic       wr_n,
    input  logic       rd_n,
    output logic [7:0] dout,
    output logic [1:0] SM,
    output logic       SM2,
    output logic       REN,
    output logic       TB8,
    output logic       SCON_RI,
    output logic       SCON_TI,
    input  logic       set_rb8,
    input  logic       rb8,
    input  logic       RI,
    input  logic       TI,
    output logic       TC,
    output logic       T7,
    output logic       irq
);

    logic [7:0] scon_r;
    logic [7:0] brl_r;
    logic [7:0] scon_base_s;
    logic [7:0] scon_nxt_s;
    logic [7:0] dout_s;
    logic       wr_scon_s;
    logic       wr_brl_s;
    logic       restart_s;
    logic       smod_s;

    assign wr_scon_s = !wr_n && (AB == ADDR_SCON);
    assign wr_brl_s  = !wr_n && (AB == ADDR_BRL);
    assign restart_s = wr_scon_s && (din[7:6] != scon_r[7:6]);

    // Hardware RI/TI set and RB8 load win over a same-cycle software write.
    always_comb begin
        scon_base_s              = wr_scon_s ? din : scon_r;
        scon_nxt_s               = scon_base_s;
        scon_nxt_s[SCON_RI_BIT]  = scon_base_s[SCON_RI_BIT] | RI;
        scon_nxt_s[SCON_TI_BIT]  = scon_base_s[SCON_TI_BIT] | TI;
        scon_nxt_s[SCON_RB8_BIT] = set_rb8 ? rb8 : scon_base_s[SCON_RB8_BIT];
    end

    // SCON and BRL registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scon_r <= 8'h00;
            brl_r  <= BRL_RESET;
        end else begin
            scon_r <= scon_nxt_s;
            if (wr_brl_s) begin
                brl_r <= din;
            end
        end
    end

`ifdef UART_SMOD_EN
    logic smod_r;

    // PCON.SMOD baud doubler bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smod_r <= 1'b0;
        end else if (!wr_n && (AB == ADDR_PCON)) begin
            smod_r <= din[7];
        end
    end

    assign smod_s = smod_r;
`else
    assign smod_s = 1'b0;
`endif

    // Combinational SFR read mux; unselected reads return zero.
    always_comb begin
        dout_s = 8'h00;
        if (rd_n) begin
            dout_s = 8'h00;
        end else if (AB == ADDR_SCON) begin
            dout_s = scon_r;
        end else if (AB == ADDR_BRL) begin
            dout_s = brl_r;
`ifdef UART_SMOD_EN
        end else if (AB == ADDR_PCON) begin
            dout_s = {smod_r, 7'd0};
`else
        end else if (AB == ADDR_PCON) begin
            dout_s = 8'h00;
`endif
        end else begin
            dout_s = 8'h00;
        end
    end

    uart_baud_gen u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (uart_mode_e'(scon_r[7:6])),
        .restart (restart_s),
        .brl     (brl_r),
        .smod    (smod_s),
        .tc      (TC),
        .t7      (T7)
    );

    assign dout    = dout_s;
    assign SM      = scon_r[7:6];
    assign SM2     = scon_r[SCON_SM2_BIT];
    assign REN     = scon_r[SCON_REN_BIT];
    assign TB8     = scon_r[SCON_TB8_BIT];
    assign SCON_RI = scon_r[SCON_RI_BIT];
    assign SCON_TI = scon_r[SCON_TI_BIT];
    assign irq     = scon_r[SCON_RI_BIT] | scon_r[SCON_TI_BIT];

endmodule

// File: doc/uart_scon_ctrl.md
# uart_scon_ctrl

Serial-port control block for the 8051-style UART. It owns the SCON register: mode, SM2, REN, TB8, RB8, TI and RI. It also generates the baud ticks that sequence the receiver and transmitter: `TC` is the 16× oversample tick and `T7` is the mode-0 shift tick. It sits between the SFR bus (`AB`/`din`/`wr_n`/`rd_n`) and the `receive`/transmit datapaths, and raises the serial interrupt.

## Interface
Parameters:
- `ADDR_SCON`, 8'h98: SCON SFR address.
- `ADDR_BRL`, 8'h9A: baud reload register address.
- `ADDR_PCON`, 8'h87: PCON address. Only used with `UART_SMOD_EN`.
- `BRL_RESET`, 8'd5: reset value of BRL.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: async active-low reset.
- `AB`, in, 8: SFR address.
- `din`, in, 8: SFR write data.
- `wr_n`, in, 1: active-low write strobe, sampled on `clk`.
- `rd_n`, in, 1: active-low read strobe.
- `dout`, out, 8: read data. It is 0 when not selected.
- `SM`, out, 2: mode {SM0,SM1} = SCON[7:6].
- `SM2`, out, 1: SCON[5].
- `REN`, out, 1: SCON[4].
- `TB8`, out, 1: SCON[3].
- `SCON_RI`, out, 1: SCON[0].
- `SCON_TI`, out, 1: SCON[1].
- `set_rb8`, in, 1: receiver strobe that loads RB8.
- `rb8`, in, 1: value written into RB8.
- `RI`, in, 1: receiver pulse that sets SCON.RI.
- `TI`, in, 1: transmitter pulse that sets SCON.TI.
- `TC`, out, 1: 16× baud tick, one clock wide.
- `T7`, out, 1: mode-0 shift tick, one clock wide.
- `irq`, out, 1: serial interrupt, equal to SCON.RI | SCON.TI.

## Operation
- **SCON write:** when `!wr_n && AB==ADDR_SCON`, SCON <= `din` on the clock edge.
- **Same-cycle priority:**
  - A hardware `RI`/`TI` pulse forces its bit to 1, overriding the written value.
  - `set_rb8` overrides the written RB8.
- **Flag clearing:** software clears RI/TI by writing 0. Hardware never clears them.
- **BRL write:** when `!wr_n && AB==ADDR_BRL`, BRL <= `din`. Counting is not disturbed; the new value is used at the next reload.
- **Read:** `dout` = SCON when `!rd_n && AB==ADDR_SCON`, BRL when `!rd_n && AB==ADDR_BRL`, otherwise 0. It is combinational.
- **Base tick by mode:**
  - Mode 00: `TC`=0. A 4-bit counter counts 0..11 and `T7` pulses when it reaches 11, i.e. every 12 clocks.
  - Mode 10: a 1-bit counter gives a base tick every 2 clocks.
  - Modes 01/11: an 8-bit down-counter reloads from BRL when it reaches 0, giving a base tick every BRL+1 clocks.
- **Divide-by-2 stage:** a stage toggles on each base tick. `TC` pulses on a base tick when the stage is 1, so `TC` runs at half the base rate.
- **Mode change:** any SCON write whose [7:6] differs from the current mode resets:
  - the divider to BRL,
  - the ÷2 stage to 0,
  - the T7 counter to 0.

  `TC`/`T7` are suppressed in that cycle.
- **REN:** has no effect on tick generation, because the transmitter also uses `TC`.
- **BRL=0 in modes 01/11:** base tick every clock, so `TC` every 2 clocks.

## Timing
- All outputs except `dout` and `irq` are registered.
- **Reset values:**
  - SCON = 0, so `SM`=00, `SM2`=`REN`=`TB8`=0 and `SCON_RI`=`SCON_TI`=0.
  - BRL = `BRL_RESET`.
  - `TC`=`T7`=0, `irq`=0.
  - All counters are 0.
- **Latency:**
  - A write is visible on the outputs the cycle after the write edge.
  - A hardware `RI` pulse in cycle n gives `SCON_RI`=1 and `irq`=1 in cycle n+1.
- **Tick timing:** the first `T7` comes 12 clocks after reset or mode entry. The first `TC` comes 2×(BRL+1) clocks after reset or mode entry.
- **Reset mid-frame:** all state returns to the reset values immediately (async). Ticks restart from count 0.

## Configuration
- **`UART_SMOD_EN` defined:**
  - Adds a PCON register bit SMOD at `ADDR_PCON`[7]. It is written and read like SCON, resets to 0, and reads back as {SMOD,7'b0}.
  - SMOD=1 bypasses the ÷2 stage, so `TC` equals the base tick: mode 10 gives `TC` every 2 clocks, and modes 01/11 give `TC` every BRL+1 clocks.
  - SMOD=0 behaves identically to the undefined case.
- **`UART_SMOD_EN` undefined:** no PCON decode, reads at `ADDR_PCON` return 0, and the ÷2 stage is always active.

## Structure
- **Shared package `uart_pkg`:**
  - mode encodings (MODE0..MODE3),
  - SCON bit indices,
  - the SFR addresses 8'h98/8'h99/8'h9A/8'h87,
  - the T7 period constant (12).

  The receive block uses the same constants.
- **Sub-module `uart_baud_gen`:** owns the divider, the ÷2 stage, the T7 counter and the mode-change restart. SCON/BRL/PCON registers and the read mux stay in the top level.

## Test plan
1. **Reset:** assert and release `rst_n`. Expect SCON read = 8'h00, BRL read = 8'h05, and no `TC` in mode 00, with `T7` every 12 clocks.
2. **Mode 01 ticks:** write SCON=8'h50, BRL=8'd3. Expect `TC` every 8 clocks, `T7`=0, `SM`=01 and `REN`=1.
3. **RI/TI priority:** in the same cycle, pulse `RI` and write SCON=8'h50. Expect SCON=8'h51 and `irq`=1. Then write 8'h50 alone and expect `irq`=0 the next cycle.
4. **set_rb8 priority:** assert `set_rb8`, `rb8`=1 in the same cycle as an SCON write with bit2=0. Expect RB8 read back as 1.
5. **Mode 10 and SMOD:** write SCON=8'h80. Expect `TC` every 4 clocks. With `UART_SMOD_EN`, then write PCON=8'h80 and expect `TC` every 2 clocks.
6. **Mode-change restart:** switch mode 01 to mode 00 mid-count. Expect `TC` to stop immediately, with the first `T7` exactly 12 clocks after the write.
